sw_seq_feeder: RTL and testbench
================================

SW_SEQ_FEEDER -- requirements
Module: sw_seq_feeder

Interface
REQ-001 Parameters: WIDTH_SCORE default 8, score width; WIDTH_POS_REF default 7, ref position width; WIDTH_POS_QUERY default 6, query position width; LEN_REF default 64, ref symbols; LEN_QUERY default 48, query symbols.
REQ-002 Ports: clk in 1, the single clock; reset in 1, asynchronous active-low reset.
REQ-003 Ports: wr_en in 1, host symbol write strobe; wr_sel in 1, 0 = ref buffer and 1 = query buffer; wr_addr in 6, symbol index; wr_data in 2, symbol.
REQ-004 Ports: start in 1, single-cycle run request; busy out 1, run in progress; done out 1, result valid; err out 1, watchdog expiry (see REQ-017).
REQ-005 Ports: valid out 1, data_ref out 2, data_query out 2, which drive the aligner's serial inputs.
REQ-006 Ports: finish in 1, max in WIDTH_SCORE, pos_ref in WIDTH_POS_REF, pos_query in WIDTH_POS_QUERY, all from the aligner.
REQ-007 Ports: res_max out WIDTH_SCORE, res_pos_ref out WIDTH_POS_REF, res_pos_query out WIDTH_POS_QUERY, the captured result.

Function
REQ-008 The FSM SHALL have states IDLE, SEND, WAIT and DONE, with all outputs registered.
REQ-009 In IDLE or DONE, wr_en SHALL write wr_data into the selected buffer at wr_addr; writes with wr_addr >= the buffer length SHALL be dropped; writes in SEND or WAIT SHALL be ignored.
REQ-010 In IDLE or DONE, start SHALL move the FSM to SEND on the next edge; clear done, err and all res_* outputs; and zero the index counter.
REQ-011 If wr_en and start occur in the same cycle, the write SHALL commit first and SHALL be visible in the transmitted stream.
REQ-012 In SEND, the block SHALL drive valid=1 for exactly LEN_REF consecutive cycles, and cycle k (k = 0..LEN_REF-1) SHALL carry data_ref=ref[k].
REQ-013 In cycle k of SEND, data_query SHALL be query[k] for k < LEN_QUERY and 2'b00 otherwise.
REQ-014 After the last SEND cycle the FSM SHALL enter WAIT with valid=0, and data_ref and data_query SHALL be held at 0 whenever valid=0.
REQ-015 In WAIT, the first cycle with finish=1 SHALL capture max, pos_ref and pos_query into the res_* outputs and enter DONE, and done SHALL rise on that same edge.
REQ-016 finish SHALL be ignored outside WAIT; done SHALL hold until the next accepted start; start SHALL be ignored while busy; busy SHALL equal (state == SEND or WAIT).
REQ-017 err SHALL stay 0 unless the SW_FEEDER_TIMEOUT_EN watchdog fires (REQ-020).
REQ-018 Latency: the first valid SHALL appear 1 cycle after start, and done SHALL appear 1 cycle after finish is sampled.

Reset
REQ-019 When reset is low, the block SHALL asynchronously force IDLE, zero all outputs and counters, and clear both buffers to 2'b00; a reset during SEND or WAIT SHALL abort the run with no done.

Configuration
REQ-020 With SW_FEEDER_TIMEOUT_EN defined, a 12-bit WAIT cycle counter SHALL force DONE with err=1 and res_* = 0 if finish has not arrived after 4095 cycles in WAIT.
REQ-021 Without SW_FEEDER_TIMEOUT_EN, the counter SHALL be absent, err SHALL be tied to 0, and WAIT SHALL be unbounded.

Structure
REQ-022 The shared package sw_pkg SHALL hold the FSM state typedef, the LEN_REF/LEN_QUERY constants, the 2-bit symbol typedef, and the timeout limit constant.
REQ-023 The block SHALL have one sub-module, sw_sym_buf: a parameterised depth x 2-bit register file with write port and combinational read, instantiated once for ref and once for query.

Verification
REQ-024 The bench SHALL cover the following directed scenarios:
- Load ref[k]=k%4 and query[k]=(k+1)%4, pulse start -> 64 valid cycles with matching symbols, data_query=0 for k=48..63, and valid=0 afterwards.
- In WAIT, drive finish=1 with max=8'd37, pos_ref=7'd20, pos_query=6'd15 -> next cycle done=1, res_max=37, res_pos_ref=20, res_pos_query=15, busy=0.
- Pulse start during SEND at k=10, and wr_en with addr 3 during WAIT -> stream unchanged, and buffer[3] unchanged on a rerun.
- Assert wr_en(sel=0, addr=0, data=3) together with start -> the first transmitted data_ref is 3; a write with addr=63 and sel=1 is dropped.
- Drive reset low at SEND k=30 -> valid=0, busy=0, done=0 immediately; after release, a new start runs a clean full stream.
- With SW_FEEDER_TIMEOUT_EN and finish never asserted -> done=1, err=1, res_max=0 at WAIT cycle 4095; without the macro the block stays in WAIT.

Source files
------------

// File: rtl/sw_pkg.sv
// Shared types and constants for the Smith-Waterman sequence feeder.
// TIMEOUT_LIMIT is only used when SW_FEEDER_TIMEOUT_EN is defined.
package sw_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_WAIT, ST_DONE} state_t;
  typedef logic [1:0] sym_t;
  localparam int LEN_REF       = 64;
  localparam int LEN_QUERY     = 48;
  localparam int TIMEOUT_LIMIT = 4095;
endpackage

// File: rtl/sw_sym_buf.sv
// Depth x 2-bit symbol register file: one write port, combinational read.
// Out-of-range writes are dropped; out-of-range reads return 2'b00.
module sw_sym_buf
  import sw_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  sym_t          i_wr_data,
  input  logic [AW-1:0] i_rd_addr,
  output sym_t          o_rd_data
);
  localparam int        DW      = DEPTH;
  localparam logic [AW:0] DEPTH_W = DW[AW:0];

  sym_t r_mem [DEPTH];
  logic w_wr_hit;
  logic w_rd_hit;

  assign w_wr_hit = i_wr_en && ({1'b0, i_wr_addr} < DEPTH_W);
  assign w_rd_hit = {1'b0, i_rd_addr} < DEPTH_W;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= 2'b00;
    end else if (w_wr_hit) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = w_rd_hit ? r_mem[i_rd_addr] : 2'b00;
endmodule

// File: rtl/sw_seq_feeder.sv
// Streams host-loaded ref/query symbols to a serial aligner and captures its result.
// Optional WAIT watchdog enabled by defining SW_FEEDER_TIMEOUT_EN.
module sw_seq_feeder #(
  parameter int WIDTH_SCORE     = 8,
  parameter int WIDTH_POS_REF   = 7,
  parameter int WIDTH_POS_QUERY = 6,
  parameter int LEN_REF         = sw_pkg::LEN_REF,
  parameter int LEN_QUERY       = sw_pkg::LEN_QUERY
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic                       wr_sel,
  input  logic [5:0]                 wr_addr,
  input  logic [1:0]                 wr_data,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic                       valid,
  output logic [1:0]                 data_ref,
  output logic [1:0]                 data_query,
  input  logic                       finish,
  input  logic [WIDTH_SCORE-1:0]     max,
  input  logic [WIDTH_POS_REF-1:0]   pos_ref,
  input  logic [WIDTH_POS_QUERY-1:0] pos_query,
  output logic [WIDTH_SCORE-1:0]     res_max,
  output logic [WIDTH_POS_REF-1:0]   res_pos_ref,
  output logic [WIDTH_POS_QUERY-1:0] res_pos_query
);
  import sw_pkg::*;

  localparam int            IW      = $clog2(LEN_REF + 1);
  localparam int            LR      = LEN_REF;
  localparam int            LQ      = LEN_QUERY;
  localparam logic [IW-1:0] IDX_END = LR[IW-1:0];
  localparam logic [IW-1:0] QRY_END = LQ[IW-1:0];

  state_t                     r_state;
  logic [IW-1:0]              r_idx;
  logic                       r_busy, r_done, r_valid;
  sym_t                       r_data_ref, r_data_query;
  logic [WIDTH_SCORE-1:0]     r_res_max;
  logic [WIDTH_POS_REF-1:0]   r_res_pos_ref;
  logic [WIDTH_POS_QUERY-1:0] r_res_pos_query;

  logic       w_wr_ok, w_we_ref, w_we_qry;
  logic [5:0] w_rd_addr;
  sym_t       w_ref_rd, w_qry_rd, w_ref_sym, w_qry_sym, w_qry_out;

  assign w_wr_ok   = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign w_we_ref  = w_wr_ok && wr_en && !wr_sel;
  assign w_we_qry  = w_wr_ok && wr_en && wr_sel;
  // r_idx is parked at 0 outside SEND, so it doubles as the read address for the start cycle.
  assign w_rd_addr = 6'(r_idx);

  sw_sym_buf #(.DEPTH(LEN_REF), .AW(6)) u_ref_buf (
    .i_clk(clk), .i_rst_n(reset), .i_wr_en(w_we_ref), .i_wr_addr(wr_addr),
    .i_wr_data(wr_data), .i_rd_addr(w_rd_addr), .o_rd_data(w_ref_rd)
  );

  sw_sym_buf #(.DEPTH(LEN_QUERY), .AW(6)) u_qry_buf (
    .i_clk(clk), .i_rst_n(reset), .i_wr_en(w_we_qry), .i_wr_addr(wr_addr),
    .i_wr_data(wr_data), .i_rd_addr(w_rd_addr), .o_rd_data(w_qry_rd)
  );

  // Forward a write landing with start so the first symbol already reflects it.
  assign w_ref_sym = (w_we_ref && (wr_addr == w_rd_addr)) ? wr_data : w_ref_rd;
  assign w_qry_sym = (w_we_qry && (wr_addr == w_rd_addr)) ? wr_data : w_qry_rd;
  assign w_qry_out = (r_idx < QRY_END) ? w_qry_sym : 2'b00;

`ifdef SW_FEEDER_TIMEOUT_EN
  localparam int          TL        = TIMEOUT_LIMIT - 1;
  localparam logic [11:0] WAIT_LAST = TL[11:0];
  logic [11:0] r_wait_cnt;
  logic        r_err;
  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state         <= ST_IDLE;
      r_idx           <= '0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_valid         <= 1'b0;
      r_data_ref      <= 2'b00;
      r_data_query    <= 2'b00;
      r_res_max       <= '0;
      r_res_pos_ref   <= '0;
      r_res_pos_query <= '0;
`ifdef SW_FEEDER_TIMEOUT_EN
      r_wait_cnt      <= '0;
      r_err           <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_state         <= ST_SEND;
            r_busy          <= 1'b1;
            r_done          <= 1'b0;
            r_res_max       <= '0;
            r_res_pos_ref   <= '0;
            r_res_pos_query <= '0;
            r_valid         <= 1'b1;
            r_data_ref      <= w_ref_sym;
            r_data_query    <= w_qry_out;
            r_idx           <= r_idx + 1'b1;
`ifdef SW_FEEDER_TIMEOUT_EN
            r_err           <= 1'b0;
`endif
          end
        end
        ST_SEND: begin
          if (r_idx == IDX_END) begin
            r_state      <= ST_WAIT;
            r_valid      <= 1'b0;
            r_data_ref   <= 2'b00;
            r_data_query <= 2'b00;
            r_idx        <= '0;
`ifdef SW_FEEDER_TIMEOUT_EN
            r_wait_cnt   <= '0;
`endif
          end else begin
            r_data_ref   <= w_ref_sym;
            r_data_query <= w_qry_out;
            r_idx        <= r_idx + 1'b1;
          end
        end
        ST_WAIT: begin
          if (finish) begin
            r_state         <= ST_DONE;
            r_busy          <= 1'b0;
            r_done          <= 1'b1;
            r_res_max       <= max;
            r_res_pos_ref   <= pos_ref;
            r_res_pos_query <= pos_query;
          end
`ifdef SW_FEEDER_TIMEOUT_EN
          else if (r_wait_cnt == WAIT_LAST) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_err   <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
`endif
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign valid         = r_valid;
  assign data_ref      = r_data_ref;
  assign data_query    = r_data_query;
  assign res_max       = r_res_max;
  assign res_pos_ref   = r_res_pos_ref;
  assign res_pos_query = r_res_pos_query;
endmodule

// File: tb/tb_sw_seq_feeder.sv
// Directed bench for sw_seq_feeder: stream content, capture, ignored inputs, write/start race,
// reset abort and WAIT watchdog (SW_FEEDER_TIMEOUT_EN selects the watchdog expectation).
module tb_sw_seq_feeder;
  logic       clk = 1'b0;
  logic       reset, wr_en, wr_sel, start, finish;
  logic [5:0] wr_addr;
  logic [1:0] wr_data;
  logic       busy, done, err, valid;
  logic [1:0] data_ref, data_query;
  logic [7:0] max, res_max;
  logic [6:0] pos_ref, res_pos_ref;
  logic [5:0] pos_query, res_pos_query;

  logic [1:0] m_ref [64];
  logic [1:0] m_qry [48];
  logic [1:0] exp_q;
  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sw_seq_feeder dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start), .busy(busy), .done(done), .err(err),
    .valid(valid), .data_ref(data_ref), .data_query(data_query), .finish(finish),
    .max(max), .pos_ref(pos_ref), .pos_query(pos_query), .res_max(res_max),
    .res_pos_ref(res_pos_ref), .res_pos_query(res_pos_query)
  );

  task automatic wr(input logic sel, input int a, input logic [1:0] d);
    wr_en = 1'b1; wr_sel = sel; wr_addr = 6'(a); wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic give_finish(input logic [7:0] m, input logic [6:0] pr, input logic [5:0] pq);
    finish = 1'b1; max = m; pos_ref = pr; pos_query = pq;
    @(negedge clk);
    finish = 1'b0;
  endtask

  task automatic test_reset;
    n_chk++; if (valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin n_fail++;
      $display("FAIL reset_ctrl: valid=%b busy=%b done=%b, want 0 0 0", valid, busy, done); end
    n_chk++; if (err !== 1'b0 || data_ref !== 2'b00 || data_query !== 2'b00) begin n_fail++;
      $display("FAIL reset_data: err=%b ref=%0d qry=%0d, want 0 0 0", err, data_ref, data_query); end
    n_chk++; if (res_max !== 8'd0 || res_pos_ref !== 7'd0 || res_pos_query !== 6'd0) begin n_fail++;
      $display("FAIL reset_res: %0d %0d %0d, want 0 0 0", res_max, res_pos_ref, res_pos_query); end
    reset = 1'b1;
    @(negedge clk);
    n_chk++; if (busy !== 1'b0 || valid !== 1'b0) begin n_fail++;
      $display("FAIL reset_release: busy=%b valid=%b, want 0 0", busy, valid); end
  endtask

  task automatic test_stream;
    for (int k = 0; k < 64; k++) begin wr(1'b0, k, 2'(k % 4)); m_ref[k] = 2'(k % 4); end
    for (int k = 0; k < 48; k++) begin wr(1'b1, k, 2'((k + 1) % 4)); m_qry[k] = 2'((k + 1) % 4); end
    start = 1'b1; @(negedge clk); start = 1'b0;
    for (int k = 0; k < 64; k++) begin
      exp_q = (k < 48) ? m_qry[k] : 2'b00;
      n_chk++; if (valid !== 1'b1 || data_ref !== m_ref[k] || data_query !== exp_q) begin n_fail++;
        $display("FAIL stream k=%0d: valid=%b ref=%0d qry=%0d, want 1 %0d %0d", k, valid, data_ref, data_query, m_ref[k], exp_q); end
      @(negedge clk);
    end
    n_chk++; if (valid !== 1'b0 || data_ref !== 2'b00 || data_query !== 2'b00 || busy !== 1'b1) begin n_fail++;
      $display("FAIL stream_tail: valid=%b ref=%0d qry=%0d busy=%b, want 0 0 0 1", valid, data_ref, data_query, busy); end
    @(negedge clk);
    n_chk++; if (valid !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin n_fail++;
      $display("FAIL wait_hold: valid=%b done=%b busy=%b, want 0 0 1", valid, done, busy); end
  endtask

  task automatic test_finish;
    give_finish(8'd37, 7'd20, 6'd15);
    n_chk++; if (done !== 1'b1 || busy !== 1'b0 || err !== 1'b0) begin n_fail++;
      $display("FAIL finish_done: done=%b busy=%b err=%b, want 1 0 0", done, busy, err); end
    n_chk++; if (res_max !== 8'd37 || res_pos_ref !== 7'd20 || res_pos_query !== 6'd15) begin n_fail++;
      $display("FAIL finish_res: %0d %0d %0d, want 37 20 15", res_max, res_pos_ref, res_pos_query); end
    give_finish(8'd5, 7'd6, 6'd7);
    repeat (3) @(negedge clk);
    n_chk++; if (done !== 1'b1 || res_max !== 8'd37 || res_pos_ref !== 7'd20 || res_pos_query !== 6'd15) begin n_fail++;
      $display("FAIL done_hold: done=%b res=%0d %0d %0d, want 1 37 20 15", done, res_max, res_pos_ref, res_pos_query); end
  endtask

  task automatic test_ignore;
    start = 1'b1; @(negedge clk); start = 1'b0;
    for (int k = 0; k < 64; k++) begin
      exp_q = (k < 48) ? m_qry[k] : 2'b00;
      n_chk++; if (valid !== 1'b1 || data_ref !== m_ref[k] || data_query !== exp_q) begin n_fail++;
        $display("FAIL ignore_stream k=%0d: valid=%b ref=%0d qry=%0d, want 1 %0d %0d", k, valid, data_ref, data_query, m_ref[k], exp_q); end
      if (k == 10) begin
        start = 1'b1; finish = 1'b1; max = 8'd99;
        wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 6'd21; wr_data = 2'd2;
      end else begin
        start = 1'b0; finish = 1'b0; wr_en = 1'b0;
      end
      @(negedge clk);
    end
    n_chk++; if (valid !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin n_fail++;
      $display("FAIL ignore_tail: valid=%b busy=%b done=%b, want 0 1 0", valid, busy, done); end
    wr(1'b0, 3, 2'd0);
    n_chk++; if (busy !== 1'b1 || done !== 1'b0) begin n_fail++;
      $display("FAIL wait_write: busy=%b done=%b, want 1 0", busy, done); end
    give_finish(8'd1, 7'd2, 6'd3);
    n_chk++; if (done !== 1'b1 || res_max !== 8'd1 || res_pos_ref !== 7'd2 || res_pos_query !== 6'd3) begin n_fail++;
      $display("FAIL ignore_done: done=%b res=%0d %0d %0d, want 1 1 2 3", done, res_max, res_pos_ref, res_pos_query); end
  endtask

  task automatic test_back_to_back;
    wr(1'b1, 63, 2'd3);
    wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 6'd0; wr_data = 2'd3; start = 1'b1;
    m_ref[0] = 2'd3;
    @(negedge clk);
    wr_en = 1'b0; start = 1'b0;
    n_chk++; if (done !== 1'b0 || busy !== 1'b1 || res_max !== 8'd0 || res_pos_ref !== 7'd0 || res_pos_query !== 6'd0) begin n_fail++;
      $display("FAIL start_clear: done=%b busy=%b res=%0d %0d %0d, want 0 1 0 0 0", done, busy, res_max, res_pos_ref, res_pos_query); end
    for (int k = 0; k < 64; k++) begin
      exp_q = (k < 48) ? m_qry[k] : 2'b00;
      n_chk++; if (valid !== 1'b1 || data_ref !== m_ref[k] || data_query !== exp_q) begin n_fail++;
        $display("FAIL b2b_stream k=%0d: valid=%b ref=%0d qry=%0d, want 1 %0d %0d", k, valid, data_ref, data_query, m_ref[k], exp_q); end
      @(negedge clk);
    end
    n_chk++; if (valid !== 1'b0 || data_query !== 2'b00) begin n_fail++;
      $display("FAIL b2b_tail: valid=%b qry=%0d, want 0 0", valid, data_query); end
    give_finish(8'd200, 7'd63, 6'd47);
    n_chk++; if (done !== 1'b1 || res_max !== 8'd200 || res_pos_ref !== 7'd63 || res_pos_query !== 6'd47) begin n_fail++;
      $display("FAIL b2b_done: done=%b res=%0d %0d %0d, want 1 200 63 47", done, res_max, res_pos_ref, res_pos_query); end
  endtask

  task automatic test_reset_abort;
    start = 1'b1; @(negedge clk); start = 1'b0;
    for (int k = 0; k <= 30; k++) begin
      n_chk++; if (valid !== 1'b1 || data_ref !== m_ref[k]) begin n_fail++;
        $display("FAIL abort_stream k=%0d: valid=%b ref=%0d, want 1 %0d", k, valid, data_ref, m_ref[k]); end
      if (k < 30) @(negedge clk);
    end
    #2 reset = 1'b0;
    #1;
    n_chk++; if (valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || data_ref !== 2'b00) begin n_fail++;
      $display("FAIL abort_async: valid=%b busy=%b done=%b ref=%0d, want 0 0 0 0", valid, busy, done, data_ref); end
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 64; k++) m_ref[k] = 2'b00;
    for (int k = 0; k < 48; k++) m_qry[k] = 2'b00;
    @(negedge clk);
    n_chk++; if (busy !== 1'b0 || done !== 1'b0 || valid !== 1'b0) begin n_fail++;
      $display("FAIL abort_idle: busy=%b done=%b valid=%b, want 0 0 0", busy, done, valid); end
    start = 1'b1; @(negedge clk); start = 1'b0;
    for (int k = 0; k < 64; k++) begin
      exp_q = (k < 48) ? m_qry[k] : 2'b00;
      n_chk++; if (valid !== 1'b1 || data_ref !== m_ref[k] || data_query !== exp_q) begin n_fail++;
        $display("FAIL clean_stream k=%0d: valid=%b ref=%0d qry=%0d, want 1 %0d %0d", k, valid, data_ref, data_query, m_ref[k], exp_q); end
      @(negedge clk);
    end
    n_chk++; if (valid !== 1'b0 || busy !== 1'b1) begin n_fail++;
      $display("FAIL clean_tail: valid=%b busy=%b, want 0 1", valid, busy); end
    give_finish(8'd9, 7'd8, 6'd7);
    n_chk++; if (done !== 1'b1 || res_max !== 8'd9) begin n_fail++;
      $display("FAIL clean_done: done=%b res_max=%0d, want 1 9", done, res_max); end
  endtask

  task automatic test_timeout;
    int n;
    start = 1'b1; @(negedge clk); start = 1'b0;
    n = 0;
    while (valid === 1'b1 && n < 100) begin @(negedge clk); n++; end
    n_chk++; if (n !== 64) begin n_fail++;
      $display("FAIL to_send_len: valid cycles=%0d, want 64", n); end
`ifdef SW_FEEDER_TIMEOUT_EN
    n = 0;
    while (done !== 1'b1 && n < 4200) begin @(negedge clk); n++; end
    n_chk++; if (n !== 4095) begin n_fail++;
      $display("FAIL to_cycle: done after %0d wait cycles, want 4095", n); end
    n_chk++; if (done !== 1'b1 || err !== 1'b1 || busy !== 1'b0 || res_max !== 8'd0) begin n_fail++;
      $display("FAIL to_state: done=%b err=%b busy=%b res_max=%0d, want 1 1 0 0", done, err, busy, res_max); end
`else
    repeat (300) @(negedge clk);
    n_chk++; if (done !== 1'b0 || err !== 1'b0 || busy !== 1'b1) begin n_fail++;
      $display("FAIL to_unbounded: done=%b err=%b busy=%b, want 0 0 1", done, err, busy); end
`endif
  endtask

  initial begin
    reset = 1'b0; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = 6'd0; wr_data = 2'd0;
    start = 1'b0; finish = 1'b0; max = 8'd0; pos_ref = 7'd0; pos_query = 6'd0;
    repeat (3) @(negedge clk);
    test_reset;
    test_stream;
    test_finish;
    test_ignore;
    test_back_to_back;
    test_reset_abort;
    test_timeout;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
